// File: rtl/aes_pkg.sv
// Shared AES definitions for the encryption datapath: round count, round-constant
// seed, GF(2^8) helpers and byte/column accessors on the 128-bit state.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ 8'h1b;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned i);
    return s[8*i +: 8];
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input int unsigned c);
    return s[32*c +: 32];
  endfunction

endpackage

// File: rtl/add_round_key_stage_if.sv
// Handshake and data bundle between the column-mixing stage, the AddRoundKey
// stage and its downstream consumer.
interface add_round_key_stage_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round;
  logic         last;

  modport master (
    output key_load, key_in, in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, round, last
  );

  modport slave (
    input  key_load, key_in, in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, round, last
  );
endinterface

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: combinational (round key, rcon) -> next round key.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon,
  output logic [127:0] next_rkey
);

  logic [31:0] w3_s;
  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [31:0] t_s;
  logic [31:0] w0n_s;
  logic [31:0] w1n_s;
  logic [31:0] w2n_s;
  logic [31:0] w3n_s;

  // RotWord moves byte 1 into byte 0 position, byte 0 wraps to the top.
  assign w3_s  = get_col(rkey, 3);
  assign rot_s = {w3_s[7:0], w3_s[31:8]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    sbox u_sbox (
      .din  (rot_s[8*g +: 8]),
      .dout (sub_s[8*g +: 8])
    );
  end

  // Column XOR chain, each new word feeding the next.
  always_comb begin
    t_s       = sub_s ^ {24'h000000, rcon};
    w0n_s     = get_col(rkey, 0) ^ t_s;
    w1n_s     = get_col(rkey, 1) ^ w0n_s;
    w2n_s     = get_col(rkey, 2) ^ w1n_s;
    w3n_s     = w3_s ^ w2n_s;
    next_rkey = {w3n_s, w2n_s, w1n_s, w0n_s};
  end

endmodule

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the affine transform.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] inv_s;

  // Inverse, then b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv_s = gf_inv(din);
    dout  = inv_s
          ^ {inv_s[6:0], inv_s[7]}
          ^ {inv_s[5:0], inv_s[7:6]}
          ^ {inv_s[4:0], inv_s[7:5]}
          ^ {inv_s[3:0], inv_s[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: XORs each accepted beat with the running round key,
// steps the key schedule per beat and wraps back to the cipher key after round NR.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR  // only 10 is meaningful here
) (
  input  logic                  clk,
  input  logic                  rst_n,
  add_round_key_stage_if.slave  bus
);

  localparam logic [3:0] LAST_RCNT = 4'(NR);

  logic [127:0] ckey_r;
  logic [127:0] rkey_r;
  logic [3:0]   rcnt_r;
  logic [7:0]   rcon_r;
  logic         key_ok_r;
  logic [127:0] state_out_r;
  logic [3:0]   round_r;
  logic         last_r;
  logic         out_valid_r;
  logic [127:0] next_rkey_s;
  logic         in_ready_s;
  logic         accept_s;
  logic         last_round_s;

  key_expand_step u_key_expand_step (
    .rkey      (rkey_r),
    .rcon      (rcon_r),
    .next_rkey (next_rkey_s)
  );

  // key_load blocks acceptance in its own cycle so the reload wins over a beat.
  assign in_ready_s   = key_ok_r & ~bus.key_load & (~out_valid_r | bus.out_ready);
  assign accept_s     = bus.in_valid & in_ready_s;
  assign last_round_s = (rcnt_r == LAST_RCNT);

  // Key schedule state: reload, per-beat advance, wrap to cipher key after round NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ckey_r   <= 128'h0;
      rkey_r   <= 128'h0;
      rcnt_r   <= 4'd0;
      rcon_r   <= RCON_INIT;
      key_ok_r <= 1'b0;
    end else if (bus.key_load) begin
      ckey_r   <= bus.key_in;
      rkey_r   <= bus.key_in;
      rcnt_r   <= 4'd0;
      rcon_r   <= RCON_INIT;
      key_ok_r <= 1'b1;
    end else if (accept_s) begin
      if (last_round_s) begin
        rkey_r <= ckey_r;
        rcnt_r <= 4'd0;
        rcon_r <= RCON_INIT;
      end else begin
        rkey_r <= next_rkey_s;
        rcnt_r <= rcnt_r + 4'd1;
        rcon_r <= xtime(rcon_r);
      end
    end else begin
      rkey_r <= rkey_r;
      rcnt_r <= rcnt_r;
      rcon_r <= rcon_r;
    end
  end

  // Output register: load on accept, drop valid on a bare consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out_r <= 128'h0;
      round_r     <= 4'd0;
      last_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      state_out_r <= bus.state_in ^ rkey_r;
      round_r     <= rcnt_r;
      last_r      <= last_round_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r & bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.state_out = state_out_r;
  assign bus.round     = round_r;
  assign bus.last      = last_r;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Randomised scoreboard bench for add_round_key_stage with a table-driven AES-128
// key-schedule reference model plus known-answer checks.
module tb_add_round_key_stage;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         lst;
  } exp_t;

  logic clk;
  logic rst_n;
  add_round_key_stage_if bus ();

  add_round_key_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  exp_t         q[$];
  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rcon_t [0:9];
  logic [127:0] rk [0:10];
  int           m_idx;
  logic         m_key_ok;
  logic         m_ov;

  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Schoolbook carry-less product reduced by long division.
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256 && a != 0; b++) begin
        if (pmul(8'(a), 8'(b)) == 8'h01) begin
          inv = 8'(b);
          break;
        end
      end
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  // Word-oriented FIPS-197 expansion into the 11 round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox_t[t[8*j +: 8]];
        t[7:0] = t[7:0] ^ rcon_t[i/4 - 1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One driver cycle: apply inputs after the falling edge, predict handshake, queue expectations.
  task automatic step(input logic kl, input logic [127:0] k, input logic iv,
                      input logic [127:0] s, input logic ordy);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    bus.key_load  = kl;
    bus.key_in    = k;
    bus.in_valid  = iv;
    bus.state_in  = s;
    bus.out_ready = ordy;
    #1;
    exp_rdy = m_key_ok & ~kl & (~m_ov | ordy);
    chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    acc = iv & exp_rdy;
    if (kl) begin
      expand(k);
      m_idx    = 0;
      m_key_ok = 1'b1;
    end
    if (acc) begin
      q.push_back('{st: s ^ rk[m_idx], rnd: 4'(m_idx), lst: (m_idx == 10)});
      m_idx = (m_idx == 10) ? 0 : m_idx + 1;
    end
    m_ov = acc | (m_ov & ~ordy);
  endtask

  // Monitor: compare whatever the DUT presents with the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got out_valid=1 expected 0 (no beat pending)");
      end else begin
        e = q[0];
        chk("sb_state_out", bus.state_out, e.st);
        chk("sb_round", 128'(bus.round), 128'(e.rnd));
        chk("sb_last", 128'(bus.last), 128'(e.lst));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [127:0] s;
    logic [127:0] k;
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    build_sbox();
    m_idx = 0; m_key_ok = 1'b0; m_ov = 1'b0;
    for (int r = 0; r < 11; r++) rk[r] = 128'h0;
    rst_n = 1'b0;
    bus.key_load = 1'b0; bus.key_in = 128'h0; bus.in_valid = 1'b0;
    bus.state_in = 128'h0; bus.out_ready = 1'b0;
    #22;
    chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'h0);
    chk("rst_state_out", bus.state_out, 128'h0);
    chk("rst_round", 128'(bus.round), 128'h0);
    chk("rst_last", 128'(bus.last), 128'h0);
    @(negedge clk); #3 rst_n = 1'b1;

    // Known answer: round-0 XOR.
    step(1'b1, K1, 1'b0, 128'h0, 1'b1);
    step(1'b0, K1, 1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b1);
    step(1'b0, K1, 1'b0, 128'h0, 1'b1);
    chk("kat_r0_state", bus.state_out, 128'hf0e0d0c0b0a090807060504030201000);
    chk("kat_r0_round", 128'(bus.round), 128'h0);
    chk("kat_r0_last", 128'(bus.last), 128'h0);

    // Full block of zeros, then a wrapped twelfth beat with no reload.
    step(1'b1, K1, 1'b0, 128'h0, 1'b1);
    s = rand128();
    for (int j = 0; j < 13; j++) begin
      step(1'b0, K1, (j < 12), (j == 11) ? s : 128'h0, 1'b1);
      if (j == 2)  chk("kat_beat1", bus.state_out, 128'hfe76abd6f178a6dafa72afd2fd74aad6);
      if (j == 11) begin
        chk("kat_beat10", bus.state_out, 128'hc5302b4d8ba707f3174a94e37f1d1113);
        chk("kat_beat10_round", 128'(bus.round), 128'd10);
        chk("kat_beat10_last", 128'(bus.last), 128'h1);
      end
    end
    chk("wrap_state", bus.state_out, s ^ K1);
    chk("wrap_round", 128'(bus.round), 128'h0);

    // Backpressure: five stalled cycles with in_valid held, then resume.
    for (int j = 0; j < 5; j++) step(1'b0, K1, 1'b1, rand128(), 1'b0);
    for (int j = 0; j < 6; j++) step(1'b0, K1, 1'b1, rand128(), 1'b1);

    // key_load at round 4 alongside in_valid, then new key from round 0.
    k = rand128();
    step(1'b1, k, 1'b0, 128'h0, 1'b1);
    for (int j = 0; j < 4; j++) step(1'b0, k, 1'b1, rand128(), 1'b1);
    k = rand128();
    step(1'b1, k, 1'b1, rand128(), 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, k, 1'b1, rand128(), 1'b1);

    // Random traffic with occasional reloads.
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 40) == 0) k = rand128();
      step(($urandom_range(0, 40) == 0), k, ($urandom_range(0, 3) != 0), rand128(),
           ($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset mid-block with a beat held on the output.
    step(1'b0, k, 1'b1, rand128(), 1'b1);
    step(1'b0, k, 1'b0, 128'h0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(bus.out_valid), 128'h0);
    chk("midrst_in_ready", 128'(bus.in_ready), 128'h0);
    q.delete();
    m_ov = 1'b0; m_key_ok = 1'b0; m_idx = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) step(1'b0, k, 1'b1, rand128(), 1'b1);
    k = rand128();
    step(1'b1, k, 1'b0, 128'h0, 1'b1);
    for (int j = 0; j < 5; j++) step(1'b0, k, 1'b1, rand128(), 1'b1);

    for (int j = 0; j < 3; j++) step(1'b0, k, 1'b0, 128'h0, 1'b1);
    chk("drain_empty", 128'(q.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
